// File: rtl/command_word_sequencer.sv
// Bus-side write sequencer for the 8259A control logic.
// Synchronises the CPU strobes, captures each write, and on the end of the strobe commits it:
// the ICW1..ICW4 init sequence is tracked, then OCW1..OCW3 are decoded in the ready state.
// Writes that are not legal in the current state are dropped, but still update the data bus.
module command_word_sequencer #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       chip_select_n,
  input  logic       read_enable_n,
  input  logic       write_enable_n,
  input  logic       address,
  input  logic [7:0] data_bus_in,
  output logic [7:0] internal_data_bus,
  output logic       write_initial_command_word_1,
  output logic       write_initial_command_word_2,
  output logic       write_initial_command_word_3,
  output logic       write_initial_command_word_4,
  output logic       write_operation_control_word_1,
  output logic       write_operation_control_word_2,
  output logic       write_operation_control_word_3,
  output logic       read,
  output logic       init_done,
  output logic [2:0] init_state
);

  typedef enum logic [2:0] {
    StUninit = 3'd0,
    StWait2  = 3'd1,
    StWait3  = 3'd2,
    StWait4  = 3'd3,
    StReady  = 3'd4
  } state_e;

  // Pulse vector bit positions.
  localparam int unsigned PIcw1 = 0;
  localparam int unsigned PIcw2 = 1;
  localparam int unsigned PIcw3 = 2;
  localparam int unsigned PIcw4 = 3;
  localparam int unsigned POcw1 = 4;
  localparam int unsigned POcw2 = 5;
  localparam int unsigned POcw3 = 6;

  logic cs_n_sync;
  logic rd_n_sync;
  logic wr_n_sync;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign cs_n_sync = chip_select_n;
      assign rd_n_sync = read_enable_n;
      assign wr_n_sync = write_enable_n;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] cs_q;
      logic [SYNC_STAGES-1:0] rd_q;
      logic [SYNC_STAGES-1:0] wr_q;

      // Strobe synchronisers; reset to the inactive (high) level.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          cs_q <= '1;
          rd_q <= '1;
          wr_q <= '1;
        end else begin
          cs_q[0] <= chip_select_n;
          rd_q[0] <= read_enable_n;
          wr_q[0] <= write_enable_n;
          for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            cs_q[i] <= cs_q[i-1];
            rd_q[i] <= rd_q[i-1];
            wr_q[i] <= wr_q[i-1];
          end
        end
      end

      assign cs_n_sync = cs_q[SYNC_STAGES-1];
      assign rd_n_sync = rd_q[SYNC_STAGES-1];
      assign wr_n_sync = wr_q[SYNC_STAGES-1];
    end
  endgenerate

  logic wr_act;
  logic rd_act;
  logic wr_act_q;
  logic commit;

  assign wr_act = ~cs_n_sync & ~wr_n_sync;
  assign rd_act = ~cs_n_sync & ~rd_n_sync;
  // Either WR_n or CS_n going inactive ends the write.
  assign commit = wr_act_q & ~wr_act;

  logic       cap_addr_q;
  logic [7:0] cap_data_q;

  // Capture address/data every cycle the write is active; the final sample is committed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_act_q   <= 1'b0;
      cap_addr_q <= 1'b0;
      cap_data_q <= 8'h00;
    end else begin
      wr_act_q <= wr_act;
      if (wr_act) begin
        cap_addr_q <= address;
        cap_data_q <= data_bus_in;
      end
    end
  end

  state_e     state_q, state_d;
  logic       sngl_q, sngl_d;
  logic       ic4_q, ic4_d;
  logic       done_q, done_d;
  logic [6:0] pulse_q, pulse_d;
  logic [7:0] bus_q, bus_d;
  logic       read_q;

  // Sequencer state and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StUninit;
      sngl_q  <= 1'b1;
      ic4_q   <= 1'b0;
      done_q  <= 1'b0;
      pulse_q <= '0;
      bus_q   <= 8'h00;
      read_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sngl_q  <= sngl_d;
      ic4_q   <= ic4_d;
      done_q  <= done_d;
      pulse_q <= pulse_d;
      bus_q   <= bus_d;
      read_q  <= rd_act & ~wr_act;
    end
  end

  logic is_icw1;
  assign is_icw1 = ~cap_addr_q & cap_data_q[4];

  // Decode each committed write against the current state.
  always_comb begin
    state_d = state_q;
    sngl_d  = sngl_q;
    ic4_d   = ic4_q;
    pulse_d = '0;
    bus_d   = bus_q;
    done_d  = (state_q == StReady);

    if (commit) begin
      bus_d = cap_data_q;
      if (is_icw1) begin
        pulse_d[PIcw1] = 1'b1;
        sngl_d         = cap_data_q[1];
        ic4_d          = cap_data_q[0];
        done_d         = 1'b0;
        state_d        = StWait2;
      end else if (cap_addr_q) begin
        case (state_q)
          StWait2: begin
            pulse_d[PIcw2] = 1'b1;
            if (!sngl_q)    state_d = StWait3;
            else if (ic4_q) state_d = StWait4;
            else            state_d = StReady;
          end
          StWait3: begin
            pulse_d[PIcw3] = 1'b1;
            state_d        = ic4_q ? StWait4 : StReady;
          end
          StWait4: begin
            pulse_d[PIcw4] = 1'b1;
            state_d        = StReady;
          end
          StReady: pulse_d[POcw1] = 1'b1;
          default: ;
        endcase
      end else if (state_q == StReady) begin
        if (cap_data_q[3]) pulse_d[POcw3] = 1'b1;
        else               pulse_d[POcw2] = 1'b1;
      end
    end

    // Unused encodings fall back to the uninitialised state.
    if (state_q > StReady) begin
      state_d = StUninit;
      pulse_d = '0;
      done_d  = 1'b0;
    end
  end

  assign internal_data_bus              = bus_q;
  assign write_initial_command_word_1   = pulse_q[PIcw1];
  assign write_initial_command_word_2   = pulse_q[PIcw2];
  assign write_initial_command_word_3   = pulse_q[PIcw3];
  assign write_initial_command_word_4   = pulse_q[PIcw4];
  assign write_operation_control_word_1 = pulse_q[POcw1];
  assign write_operation_control_word_2 = pulse_q[POcw2];
  assign write_operation_control_word_3 = pulse_q[POcw3];
  assign read                           = read_q;
  assign init_done                      = done_q;
  assign init_state                     = state_q;

endmodule
